tia_playfield_shifter: RTL and testbench
========================================

# tia_playfield_shifter

Parametrised playfield serializer: holds a WIDTH-bit playfield pattern and emits it one bit per PIXELS_PER_BIT pixel-clock enables, across two half-lines per scan. The right half can repeat the left half (copy) or mirror it (reflect). It replaces chained hand-built playfield register cells with a single-clock, counter-driven block. It sits between the register-write decode (load) and the TIA pixel mixer (out).

## Interface
- WIDTH, 20, playfield bits per half-line; WIDTH >= 2
- PIXELS_PER_BIT, 4, pixel enables per playfield bit; >= 1
- clk  in  1  system clock; all state changes on rising edge
- r  in  1  reset, synchronous, active-high
- load  in  1  write strobe; captures load_data into the pattern register
- load_data  in  WIDTH  new pattern; bit 0 is the leftmost bit of the left half
- reflect  in  1  mode for the right half: 0 = copy, 1 = mirror; sampled when the right half begins
- start  in  1  begin a new scan at the left half
- advance  in  1  pixel-clock enable; one pixel per asserted cycle
- out  out  1  registered playfield pixel
- half  out  1  0 = left half, 1 = right half (valid while busy)
- busy  out  1  high while in LEFT or RIGHT
- done  out  1  one-cycle pulse when the right half completes

## Operation
- States: IDLE, LEFT, RIGHT.
- Counters:
  - sub, $clog2(PIXELS_PER_BIT) bits, minimum 1 bit, counts 0..PIXELS_PER_BIT-1.
  - idx, $clog2(WIDTH) bits, counts 0..WIDTH-1.
  - rmode, 1-bit latched copy of reflect.
- Pattern register pat: written from load_data on any cycle with load=1, in every state.
- Bit select:
  - LEFT uses pat[idx].
  - RIGHT uses pat[idx] when rmode=0, and pat[WIDTH-1-idx] when rmode=1.
- Transitions and actions on an advance cycle in LEFT or RIGHT:
  - out <= the selected bit.
  - sub increments. When sub = PIXELS_PER_BIT-1, sub <= 0 and idx increments.
  - When idx = WIDTH-1 and sub = PIXELS_PER_BIT-1:
    - LEFT goes to RIGHT with idx <= 0, sub <= 0, rmode <= reflect.
    - RIGHT goes to IDLE and done <= 1 on the next cycle.
- IDLE with advance=1: out <= 0.
- start=1 in any state:
  - state <= LEFT, idx <= 0, sub <= 0.
  - out is unchanged on that cycle; this restarts a scan already in progress.
- start has priority over advance in the same cycle; that advance emits no pixel.
- load and advance in the same cycle: the pixel uses the old pat value. The new value is visible from the next advance.
- Cycles with advance=0: no counter, state or out change except for start and load.
- half = (state == RIGHT). busy = (state != IDLE).

## Timing
- Reset values: state IDLE, pat 0, idx 0, sub 0, rmode 0, out 0, done 0, half 0, busy 0.
- r overrides start, load and advance in the same cycle. Reset mid-scan aborts to IDLE without a done pulse.
- Latency: out reflects the pixel selected on an advance cycle starting on the next clock edge. out holds until the next advance.
- Each half is exactly WIDTH*PIXELS_PER_BIT advances. A scan is 2*WIDTH*PIXELS_PER_BIT advances from start to done.
- done is asserted the cycle after the final advance and lasts exactly 1 cycle. busy drops in that same cycle.
- rmode is captured on the LEFT-to-RIGHT advance. Changing reflect mid-RIGHT has no effect until the next scan.
- Counter wrap: idx and sub never exceed their terminal values, including for non-power-of-two WIDTH.

## Test plan
- Reset: hold r with start=1, advance=1 -> out=0, busy=0, done=0 and pat=0 throughout.
- Copy mode, defaults: load 20'h00001, reflect=0, start, 160 advances every cycle.
  - out=1 for pixels 0-3 and 80-83, 0 elsewhere.
  - done pulses on the cycle after advance 160.
- Reflect mode: load 20'h00001, reflect=1, 160 advances.
  - out=1 for pixels 0-3 and 156-159.
  - half=1 exactly from pixel 80 onward.
- Mid-scan load: load 20'hFFFFF on the same cycle as advance 40.
  - Pixel 40 uses the old pattern (0); pixels 41 onward are 1.
  - A load one cycle before the advance is visible on that advance.
- Restart and sparse enables: advance every 3rd cycle with WIDTH=5, PIXELS_PER_BIT=1.
  - Assert start at pixel 7 -> idx/sub reset, no done pulse.
  - 10 further advances -> single done pulse.
- Reset mid-RIGHT: assert r at pixel 100 -> next cycle IDLE, out=0, busy=0, no done; a later start scans normally.

Source files
------------

// File: rtl/tia_playfield_shifter_if.sv
// Bundles the pattern-load, scan-control and pixel-output signals of the
// playfield serializer so the register decode and the pixel mixer share one port.
interface tia_playfield_shifter_if #(
    parameter int WIDTH = 20
);
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             reflect;
    logic             start;
    logic             advance;
    logic             out;
    logic             half;
    logic             busy;
    logic             done;

    modport master (
        output load, load_data, reflect, start, advance,
        input  out, half, busy, done
    );

    modport slave (
        input  load, load_data, reflect, start, advance,
        output out, half, busy, done
    );
endinterface

// File: rtl/tia_playfield_shifter.sv
// Playfield serializer.
//
// It shifts out a WIDTH-bit pattern one bit per PIXELS_PER_BIT pixel enables.
// A scan has two half-lines. The right half either repeats the pattern or
// mirrors it.
//
// state | meaning
// IDLE  | no scan active; an advance drives a blank (0) pixel
// LEFT  | emitting the left half, pat[idx]
// RIGHT | emitting the right half, pat[idx] or pat[WIDTH-1-idx] per rmode
module tia_playfield_shifter #(
    parameter int WIDTH          = 20,
    parameter int PIXELS_PER_BIT = 4
) (
    input logic                      clk,
    input logic                      r,
    tia_playfield_shifter_if.slave   pf
);
    localparam int SUB_W = (PIXELS_PER_BIT > 1) ? $clog2(PIXELS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PIXELS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             rmode_q, rmode_d;
    logic             out_q, out_d;
    logic             done_q, done_d;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_bit;
    logic             sub_last;
    logic             idx_last;

    // Pick the pattern bit for the current position; the mirror only applies to the right half.
    always_comb begin
        sel_idx = idx_q;
        if (state_q == S_RIGHT && rmode_q) begin
            sel_idx = IDX_LAST - idx_q;
        end
        sel_bit  = pat_q[sel_idx];
        sub_last = (sub_q == SUB_LAST);
        idx_last = (idx_q == IDX_LAST);
    end

    // Next-state logic: start restarts the scan and wins over advance; load is independent.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        rmode_d = rmode_q;
        out_d   = out_q;
        done_d  = 1'b0;
        pat_d   = pf.load ? pf.load_data : pat_q;

        if (pf.start) begin
            state_d = S_LEFT;
            idx_d   = '0;
            sub_d   = '0;
        end else if (pf.advance) begin
            case (state_q)
                S_LEFT, S_RIGHT: begin
                    out_d = sel_bit;
                    if (sub_last) begin
                        sub_d = '0;
                        if (idx_last) begin
                            idx_d = '0;
                            if (state_q == S_LEFT) begin
                                state_d = S_RIGHT;
                                rmode_d = pf.reflect;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                default: begin
                    out_d = 1'b0;
                end
            endcase
        end
    end

    // Register all state; reset aborts any scan without a done pulse.
    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            sub_q   <= '0;
            rmode_q <= 1'b0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            rmode_q <= rmode_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign pf.out  = out_q;
    assign pf.done = done_q;
    assign pf.half = (state_q == S_RIGHT);
    assign pf.busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_tia_playfield_shifter.sv
// Bench for the playfield serializer.
// Two instances are driven with the same stimulus: the default 20x4 build and a
// 5x1 build. A position-based reference model pushes the expected outputs for
// every cycle, and a monitor pops and compares them after each clock edge.
module tb_tia_playfield_shifter;
    logic clk;
    logic r;

    tia_playfield_shifter_if #(.WIDTH(20)) if0 ();
    tia_playfield_shifter_if #(.WIDTH(5))  if1 ();

    tia_playfield_shifter #(.WIDTH(20), .PIXELS_PER_BIT(4)) dut0 (
        .clk (clk),
        .r   (r),
        .pf  (if0)
    );

    tia_playfield_shifter #(.WIDTH(5), .PIXELS_PER_BIT(1)) dut1 (
        .clk (clk),
        .r   (r),
        .pf  (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        logic [3:0] e0;   // {out, half, busy, done}
        logic [3:0] e1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: a scan is a pixel position 0 .. 2*W*P-1.
    int         m_pos[2];
    bit         m_act[2];
    bit         m_rmode[2];
    logic [19:0] m_pat[2];
    bit         m_out[2];
    bit         m_done[2];

    function automatic int mw(input int k);
        return (k == 0) ? 20 : 5;
    endfunction

    function automatic int mp(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_step(input int k, input bit ri, input bit st, input bit ld,
                              input logic [19:0] d, input bit rf, input bit adv);
        int w, p, b, j;
        w = mw(k);
        p = mp(k);
        m_done[k] = 1'b0;
        if (ri) begin
            m_pos[k]   = 0;
            m_act[k]   = 1'b0;
            m_rmode[k] = 1'b0;
            m_pat[k]   = '0;
            m_out[k]   = 1'b0;
        end else begin
            if (st) begin
                m_act[k] = 1'b1;
                m_pos[k] = 0;
            end else if (adv) begin
                if (!m_act[k]) begin
                    m_out[k] = 1'b0;
                end else begin
                    b = m_pos[k] / p;
                    if (b < w) begin
                        m_out[k] = m_pat[k][b];
                    end else begin
                        j = b - w;
                        m_out[k] = m_rmode[k] ? m_pat[k][w-1-j] : m_pat[k][j];
                    end
                    if (m_pos[k] == w*p - 1) m_rmode[k] = rf;
                    m_pos[k]++;
                    if (m_pos[k] == 2*w*p) begin
                        m_act[k]  = 1'b0;
                        m_pos[k]  = 0;
                        m_done[k] = 1'b1;
                    end
                end
            end
            if (ld) m_pat[k] = (k == 0) ? d : {15'd0, d[4:0]};
        end
    endtask

    function automatic logic [3:0] model_exp(input int k);
        bit h;
        h = m_act[k] && (m_pos[k] >= mw(k) * mp(k));
        return {m_out[k], h, m_act[k], m_done[k]};
    endfunction

    task automatic chk(input string nm, input int cyc, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    // Drive one clock of stimulus and record what both instances must show after it.
    task automatic drive(input bit ri, input bit st, input bit ld, input logic [19:0] d,
                         input bit rf, input bit adv);
        exp_t e;
        @(negedge clk);
        r             = ri;
        if0.start     = st;   if1.start     = st;
        if0.load      = ld;   if1.load      = ld;
        if0.load_data = d;    if1.load_data = d[4:0];
        if0.reflect   = rf;   if1.reflect   = rf;
        if0.advance   = adv;  if1.advance   = adv;
        model_step(0, ri, st, ld, d, rf, adv);
        model_step(1, ri, st, ld, d, rf, adv);
        cycle++;
        e.cyc = cycle;
        e.e0  = model_exp(0);
        e.e1  = model_exp(1);
        exp_q.push_back(e);
    endtask

    // Monitor: compare after every edge whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("w20_out",  e.cyc, if0.out,  e.e0[3]);
                chk("w20_half", e.cyc, if0.half, e.e0[2]);
                chk("w20_busy", e.cyc, if0.busy, e.e0[1]);
                chk("w20_done", e.cyc, if0.done, e.e0[0]);
                chk("w5_out",   e.cyc, if1.out,  e.e1[3]);
                chk("w5_half",  e.cyc, if1.half, e.e1[2]);
                chk("w5_busy",  e.cyc, if1.busy, e.e1[1]);
                chk("w5_done",  e.cyc, if1.done, e.e1[0]);
            end
        end
    end

    initial begin
        int n;
        int budget;
        r = 1'b1;
        if0.start = 0; if0.load = 0; if0.load_data = '0; if0.reflect = 0; if0.advance = 0;
        if1.start = 0; if1.load = 0; if1.load_data = '0; if1.reflect = 0; if1.advance = 0;
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = 0; m_act[k] = 0; m_rmode[k] = 0; m_pat[k] = '0; m_out[k] = 0; m_done[k] = 0;
        end

        // Reset dominates start, load and advance.
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 20'hABCDE, 1, 1);
        drive(0, 0, 0, 20'h0, 0, 1);

        // Copy mode, single set bit.
        drive(0, 0, 1, 20'h00001, 0, 0);
        drive(0, 1, 0, 20'h0, 0, 0);
        for (int i = 0; i < 160; i++) drive(0, 0, 0, 20'h0, 0, 1);
        for (int i = 0; i < 3; i++)   drive(0, 0, 0, 20'h0, 0, 0);

        // Reflect mode; reflect dropped mid-right must not matter.
        drive(0, 1, 0, 20'h0, 1, 0);
        for (int i = 0; i < 160; i++) drive(0, 0, 0, 20'h0, (i < 100), 1);
        drive(0, 0, 0, 20'h0, 0, 0);

        // Mid-scan load on the same cycle as advance 40, then a load one cycle ahead.
        drive(0, 0, 1, 20'h00000, 0, 0);
        drive(0, 1, 0, 20'h0, 0, 0);
        for (int i = 0; i < 40; i++) drive(0, 0, 0, 20'h0, 0, 1);
        drive(0, 0, 1, 20'hFFFFF, 0, 1);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 20'h0, 0, 1);
        drive(0, 0, 1, 20'h5A5A5, 0, 0);
        for (int i = 0; i < 99; i++) drive(0, 0, 0, 20'h0, 1, 1);
        drive(0, 0, 0, 20'h0, 0, 0);

        // Sparse enables with a restart at pixel 7.
        drive(0, 0, 1, 20'h00013, 0, 0);
        drive(0, 1, 0, 20'h0, 0, 0);
        n = 0;
        for (int i = 0; i < 21; i++) drive(0, 0, 0, 20'h0, 1, (i % 3 == 0));
        drive(0, 1, 0, 20'h0, 1, 1);
        for (int i = 0; i < 36; i++) drive(0, 0, 0, 20'h0, 0, (i % 3 == 0));

        // Reset mid-right, then a clean scan.
        drive(0, 1, 1, 20'h8000F, 1, 0);
        for (int i = 0; i < 100; i++) drive(0, 0, 0, 20'h0, 1, 1);
        drive(1, 0, 0, 20'h0, 0, 1);
        drive(0, 0, 0, 20'h0, 0, 1);
        drive(0, 0, 1, 20'h3C0F1, 0, 0);
        drive(0, 1, 0, 20'h0, 1, 0);
        for (int i = 0; i < 162; i++) drive(0, 0, 0, 20'h0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 5),
                  20'($urandom),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 99) < 65));
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 20'h0, 0, 0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
